vga_scanout: RTL

Scan-out engine for the tetris display: generates 640x480@60 VGA timing from the pixel clock and reads the 256x240 8-bit frame buffer through the dual-port video RAM's read-only port B. It doubles each stored pixel 2x2 into a centred 512x480 window and drives the RRRGGGBB colour pins. Game logic owns the RAM's write port A; this block is the consumer at the other end of that memory.

---
 rtl/vga_pkg.sv | 56 +++++
 rtl/vga_timing.sv | 72 +++++++
 rtl/vga_scanout.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: default 640x480@60 timing, frame-buffer
// geometry, colour packing and the control word carried down the pipeline.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_OFFSET  = 64;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int FB_WIDTH   = 256;
  localparam int FB_HEIGHT  = 240;
  localparam int WIN_WIDTH  = 2 * FB_WIDTH;
  localparam int WIN_HEIGHT = 2 * FB_HEIGHT;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  typedef struct packed {
    logic visible;
    logic window;
    logic hsync;
    logic vsync;
    logic vblank;
    logic frame_start;
  } ctl_t;

  // Idle word keeps sync deasserted so a flushed pipeline cannot emit a pulse
  localparam ctl_t CTL_IDLE = '{
    visible:     1'b0,
    window:      1'b0,
    hsync:       1'b1,
    vsync:       1'b1,
    vblank:      1'b0,
    frame_start: 1'b0
  };

  function automatic rgb_t to_rgb(input logic [7:0] pixel);
    rgb_t c;
    c.r = pixel[7:5];
    c.g = pixel[4:2];
    c.b = pixel[1:0];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the scan-out engine plus the raw per-position flags
// (visible area, frame-buffer window, sync terms, vblank, frame origin).
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int H_OFFSET  = DEF_H_OFFSET,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h_r,
  output logic [VW-1:0] v_r,
  output logic          visible_s,
  output logic          window_s,
  output logic          hsync_s,
  output logic          vsync_s,
  output logic          vblank_s,
  output logic          origin_s
);

  // Window rows never extend past the frame buffer, even on a taller raster
  localparam int V_WIN_ROWS = (V_VISIBLE < WIN_HEIGHT) ? V_VISIBLE : WIN_HEIGHT;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] WIN_START = HW'(H_OFFSET);
  localparam logic [HW-1:0] WIN_END   = HW'(H_OFFSET + WIN_WIDTH);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_WIN_END = VW'(V_WIN_ROWS);

  // Raster position: h advances every clk, v advances when h wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_r <= '0;
      v_r <= '0;
    end else if (h_r == H_LAST) begin
      h_r <= '0;
      if (v_r == V_LAST) begin
        v_r <= '0;
      end else begin
        v_r <= v_r + 1'b1;
      end
    end else begin
      h_r <= h_r + 1'b1;
    end
  end

  assign visible_s = (h_r < H_VIS_END) && (v_r < V_VIS_END);
  assign window_s  = (h_r >= WIN_START) && (h_r < WIN_END) && (v_r < V_WIN_END);
  assign hsync_s   = !((h_r >= HS_START) && (h_r < HS_END));
  assign vsync_s   = !((v_r >= VS_START) && (v_r < VS_END));
  assign vblank_s  = (v_r >= V_VIS_END);
  assign origin_s  = (h_r == '0) && (v_r == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: reads the 256x240 frame buffer through RAM port B, doubles it
// 2x2 into a centred 512x480 window and drives RRRGGGBB plus syncs, 3 clks behind the counters.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VISIBLE          = DEF_H_VISIBLE,
  parameter int H_FRONT            = DEF_H_FRONT,
  parameter int H_SYNC             = DEF_H_SYNC,
  parameter int H_BACK             = DEF_H_BACK,
  parameter int V_VISIBLE          = DEF_V_VISIBLE,
  parameter int V_FRONT            = DEF_V_FRONT,
  parameter int V_SYNC             = DEF_V_SYNC,
  parameter int V_BACK             = DEF_V_BACK,
  parameter int H_OFFSET           = DEF_H_OFFSET,
  parameter logic [7:0] BORDER_COLOR = 8'h00,
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam int VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [HW-1:0] H_OFF_C = HW'(H_OFFSET);

  logic [HW-1:0]         h_s;
  logic [VW-1:0]         v_s;
  logic                  visible_s;
  logic                  window_s;
  logic                  hsync_raw_s;
  logic                  vsync_raw_s;
  logic                  vblank_raw_s;
  logic                  origin_s;
  ctl_t                  ctl0_s;
  ctl_t                  ctl1_r;
  ctl_t                  ctl2_r;
  logic [7:0]            fb_x_s;
  logic [7:0]            fb_y_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [7:0]            pix_s;
  rgb_t                  rgb_s;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .H_OFFSET  (H_OFFSET)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .h_r       (h_s),
    .v_r       (v_s),
    .visible_s (visible_s),
    .window_s  (window_s),
    .hsync_s   (hsync_raw_s),
    .vsync_s   (vsync_raw_s),
    .vblank_s  (vblank_raw_s),
    .origin_s  (origin_s)
  );

  assign ctl0_s = '{
    visible:     visible_s,
    window:      window_s,
    hsync:       hsync_raw_s,
    vsync:       vsync_raw_s,
    vblank:      vblank_raw_s,
    frame_start: origin_s
  };

  // Pixel doubling is just dropping the LSB of each coordinate; row-major
  // 256-wide layout makes the address a plain concatenation.
  assign fb_x_s = 8'((h_s - H_OFF_C) >> 1);
  assign fb_y_s = 8'(v_s >> 1);
  assign addr_s = window_s ? ADDR_WIDTH'({fb_y_s, fb_x_s}) : '0;

  // S1/S2: registered RAM address and the flag delay line matching the read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_b <= '0;
      ctl1_r <= CTL_IDLE;
      ctl2_r <= CTL_IDLE;
    end else begin
      addr_b <= addr_s;
      ctl1_r <= ctl0_s;
      ctl2_r <= ctl1_r;
    end
  end

  // Colour source for the pixel whose RAM data is on q_b this cycle
  always_comb begin
    pix_s = 8'h00;
    if (ctl2_r.window) begin
      pix_s = 8'(q_b);
    end else if (ctl2_r.visible) begin
      pix_s = BORDER_COLOR;
    end else begin
      pix_s = 8'h00;
    end
  end

  assign rgb_s = to_rgb(pix_s);

  // S3: colour and sync share one register bank so they stay cycle-aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= 3'b000;
      vga_g       <= 3'b000;
      vga_b       <= 2'b00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= rgb_s.r;
      vga_g       <= rgb_s.g;
      vga_b       <= rgb_s.b;
      hsync       <= ctl2_r.hsync;
      vsync       <= ctl2_r.vsync;
      vblank      <= ctl2_r.vblank;
      frame_start <= ctl2_r.frame_start;
    end
  end

endmodule
